// File: rtl/spi_sample_rx_pkg.sv
// Shared definitions for the SPI sample receiver: FSM encoding, nibble field
// offsets inside each 4-bit I/Q sample, and the default word width.
package spi_sample_rx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;

  // Bit positions inside one nibble = {I1,I0,Q1,Q0}
  localparam int I1_BIT = 3;
  localparam int I0_BIT = 2;
  localparam int Q1_BIT = 1;
  localparam int Q0_BIT = 0;

  localparam int NIB_BITS      = 4;
  localparam int DEF_WORD_BITS = 8;

endpackage

// File: rtl/spi_sample_rx_sync.sv
// Multi-flop pin synchronizer; RST_VAL sets the value every stage (and thus the
// output register) takes in reset, so a deselected SS can come up as 1.
module spi_sample_rx_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_chain <= {STAGES{RST_VAL}};
    else       r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/spi_sample_rx.sv
// SPI mode-0 slave receiver, oversampled in the MCU_CLK_25_000 domain, with a
// valid/ready holding register. Define SPI_RX_STATS_EN to add WORD_CNT/DROP_CNT.
module spi_sample_rx
  import spi_sample_rx_pkg::*;
#(
  parameter int WORD_BITS   = DEF_WORD_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 MCU_CLK_25_000,
  input  logic                 RESET_P,
  input  logic                 SPI_SCK,
  input  logic                 SPI_SS,
  input  logic                 SPI_MOSI,
  input  logic                 RX_READY,
  input  logic                 ERR_CLR,
  output logic [WORD_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  output logic                 OVERRUN,
  output logic                 FRAME_ERR
`ifdef SPI_RX_STATS_EN
  ,
  output logic [15:0]          WORD_CNT,
  output logic [7:0]           DROP_CNT
`endif
);

  localparam int             CW   = $clog2(WORD_BITS);
  localparam logic [CW-1:0]  LAST = CW'(WORD_BITS - 1);

  logic w_sck_s, w_ss_s, w_mosi_s;

  spi_sample_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .i_clk(MCU_CLK_25_000), .i_rst(RESET_P), .i_d(SPI_SCK), .o_q(w_sck_s));
  spi_sample_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .i_clk(MCU_CLK_25_000), .i_rst(RESET_P), .i_d(SPI_SS), .o_q(w_ss_s));
  spi_sample_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(MCU_CLK_25_000), .i_rst(RESET_P), .i_d(SPI_MOSI), .o_q(w_mosi_s));

  rx_state_e            r_state;
  logic                 r_sck_d;
  logic [WORD_BITS-1:0] r_shift;
  logic [CW-1:0]        r_cnt;
  logic                 r_done;
  logic                 r_ferr;
  logic                 w_rise;

  assign w_rise = w_sck_s & ~r_sck_d;

  // r_shift keeps the completed word untouched until the next SCK rise, which is
  // several clocks away, so the holder can load straight from it on r_done.
  always_ff @(posedge MCU_CLK_25_000 or posedge RESET_P) begin
    if (RESET_P) begin
      r_state <= ST_IDLE;
      r_sck_d <= 1'b0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sck_d <= w_sck_s;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_ss_s) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_ss_s) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ferr  <= (r_cnt != '0);
          end else if (w_rise) begin
            r_shift <= {r_shift[WORD_BITS-2:0], w_mosi_s};
            if (r_cnt == LAST) begin
              r_cnt  <= '0;
              r_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign FRAME_ERR = r_ferr;

  logic w_load, w_drop;
  assign w_load = r_done & (~RX_VALID | RX_READY);
  assign w_drop = r_done & RX_VALID & ~RX_READY;

  always_ff @(posedge MCU_CLK_25_000 or posedge RESET_P) begin
    if (RESET_P) begin
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      if (w_load) begin
        RX_DATA  <= r_shift;
        RX_VALID <= 1'b1;
      end else if (RX_VALID && RX_READY) begin
        RX_VALID <= 1'b0;
      end
      // A fresh drop outranks a same-cycle clear
      if (w_drop)       OVERRUN <= 1'b1;
      else if (ERR_CLR) OVERRUN <= 1'b0;
    end
  end

`ifdef SPI_RX_STATS_EN
  always_ff @(posedge MCU_CLK_25_000 or posedge RESET_P) begin
    if (RESET_P) begin
      WORD_CNT <= '0;
      DROP_CNT <= '0;
    end else begin
      if (w_load) WORD_CNT <= WORD_CNT + 16'd1;
      if (w_drop) DROP_CNT <= DROP_CNT + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_sample_rx.sv
// Scoreboard bench for spi_sample_rx: stimulus pushes expected words, a negedge
// monitor pops them on each RX_VALID & RX_READY handshake.
module tb_spi_sample_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sck = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       rdy = 1'b0;
  logic       eclr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, ovr, ferr;
`ifdef SPI_RX_STATS_EN
  logic [15:0] word_cnt;
  logic [7:0]  drop_cnt;
`endif

  spi_sample_rx dut (
    .MCU_CLK_25_000(clk),
    .RESET_P       (rst),
    .SPI_SCK       (sck),
    .SPI_SS        (ss),
    .SPI_MOSI      (mosi),
    .RX_READY      (rdy),
    .ERR_CLR       (eclr),
    .RX_DATA       (rx_data),
    .RX_VALID      (rx_valid),
    .OVERRUN       (ovr),
    .FRAME_ERR     (ferr)
`ifdef SPI_RX_STATS_EN
    ,
    .WORD_CNT      (word_cnt),
    .DROP_CNT      (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0, n_err = 0;
  logic [7:0] exp_q[$];
  int         exp_loads = 0, exp_drops = 0, exp_ferr = 0, ferr_seen = 0;
  int         rise_cnt = 0, last_rise_cyc = 0;
  logic       prev_ferr = 1'b0;
  logic       any_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes expected words on handshakes, tracks FRAME_ERR pulses
  always @(negedge clk) begin
    logic [7:0] w;
    if (!rst) begin
      any_valid <= any_valid | rx_valid;
      if (rx_valid && rdy) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word (t=%0t)", rx_data, $time);
        end else begin
          w = exp_q.pop_front();
          check("rx_data", int'(rx_data), int'(w));
        end
      end
      if (ferr) begin
        ferr_seen++;
        check("frame_err_width", int'(prev_ferr), 0);
      end
      prev_ferr = ferr;
    end else begin
      prev_ferr = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n, input int half);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = v[i];
      tick(half);
      sck = 1'b1;
      rise_cnt++;
      last_rise_cyc = cyc;
      tick(half);
      sck = 1'b0;
    end
  endtask

  task automatic ss_begin();
    ss = 1'b0;
    tick(3);
  endtask

  task automatic ss_end();
    tick(2);
    ss = 1'b1;
    tick(4);
  endtask

  task automatic expect_load(input logic [7:0] v);
    exp_q.push_back(v);
    exp_loads++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    check("reset_valid", int'(rx_valid), 0);
    check("reset_data", int'(rx_data), 0);
    check("reset_overrun", int'(ovr), 0);
    check("reset_frame_err", int'(ferr), 0);
    rst = 1'b0;
    exp_loads = 0;
    exp_drops = 0;
    tick(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish within time bound");
    $fatal(1);
  end

  initial begin
    int k, got, target, half, n, r;
    logic [7:0] v;
    #1;
    do_reset();

    // 1: single word at max SCK, latency and one-cycle valid
    rdy = 1'b1;
    ss_begin();
    expect_load(8'hA5);
    send_bits(8'hA5, 8, 2);
    k = last_rise_cyc;
    got = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_valid) begin got = cyc; break; end
    end
    check("t1_latency", got - k, 4);
    check("t1_data", int'(rx_data), 8'hA5);
    @(negedge clk);
    check("t1_valid_one_cycle", int'(rx_valid), 0);
    ss_end();

    // 2: back-to-back words with consumer stalled -> overrun, then clear
    rdy = 1'b0;
    ss_begin();
    expect_load(8'h12);
    send_bits(8'h12, 8, 2);
    exp_drops++;
    send_bits(8'h34, 8, 2);
    ss_end();
    @(negedge clk);
    check("t2_data", int'(rx_data), 8'h12);
    check("t2_valid", int'(rx_valid), 1);
    check("t2_overrun", int'(ovr), 1);
    tick(1);
    eclr = 1'b1;
    tick(1);
    eclr = 1'b0;
    @(negedge clk);
    check("t2_overrun_clr", int'(ovr), 0);
    check("t2_data_kept", int'(rx_data), 8'h12);
    tick(1);
    rdy = 1'b1;
    tick(3);

    // 3: partial frame -> FRAME_ERR, then a clean word
    ss_begin();
    send_bits(8'($urandom), 5, 3);
    exp_ferr++;
    ss_end();
    ss_begin();
    expect_load(8'h3C);
    send_bits(8'h3C, 8, 2);
    ss_end();
    check("t3_data", int'(rx_data), 8'h3C);

    // 4: accept of old word coincides with completion of new word
    rdy = 1'b0;
    ss_begin();
    expect_load(8'h77);
    send_bits(8'h77, 8, 2);
    expect_load(8'h99);
    target = rise_cnt + 8;
    fork
      send_bits(8'h99, 8, 2);
      begin
        wait (rise_cnt == target);
        repeat (3) @(posedge clk);
        #1 rdy = 1'b1;
        @(posedge clk);
        #1 rdy = 1'b0;
      end
    join
    @(negedge clk);
    check("t4_valid", int'(rx_valid), 1);
    check("t4_data", int'(rx_data), 8'h99);
    check("t4_overrun", int'(ovr), 0);
    ss_end();
    rdy = 1'b1;
    tick(3);

    // Randomized traffic: mixed SCK rates, continuous/split frames, partial frames
    ss_begin();
    for (int i = 0; i < 24; i++) begin
      r    = int'($urandom_range(0, 9));
      half = int'($urandom_range(2, 4));
      if (r < 2) begin
        n = int'($urandom_range(1, 7));
        send_bits(8'($urandom), n, half);
        exp_ferr++;
        ss_end();
        ss_begin();
      end else begin
        v = 8'($urandom);
        expect_load(v);
        send_bits(v, 8, half);
        if (r == 9) begin
          ss_end();
          ss_begin();
        end
      end
    end
    ss_end();

    // 5: reset mid-word, SCK with SS high ignored, then a full word
    ss_begin();
    send_bits(8'($urandom), 3, 2);
    do_reset();
    ss_end();
    any_valid = 1'b0;
    for (int i = 0; i < 2; i++) send_bits(8'($urandom), 8, 2);
    tick(6);
    check("t5_no_valid_ss_high", int'(any_valid), 0);
    ss_begin();
    expect_load(8'h5A);
    send_bits(8'h5A, 8, 2);
    ss_end();
    check("t5_data", int'(rx_data), 8'h5A);

    // 6: two more loads and one drop since reset
    ss_begin();
    expect_load(8'h11);
    send_bits(8'h11, 8, 2);
    tick(4);
    rdy = 1'b0;
    expect_load(8'h22);
    send_bits(8'h22, 8, 2);
    exp_drops++;
    send_bits(8'h33, 8, 2);
    ss_end();
    check("t6_overrun", int'(ovr), 1);
    check("t6_data", int'(rx_data), 8'h22);
`ifdef SPI_RX_STATS_EN
    check("t6_word_cnt", int'(word_cnt), exp_loads);
    check("t6_drop_cnt", int'(drop_cnt), exp_drops);
`endif
    rdy = 1'b1;
    tick(10);

    check("queue_drained", exp_q.size(), 0);
    check("frame_err_count", ferr_seen, exp_ferr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
